// File: rtl/mano_pkg.sv
// Shared definitions for the basic-computer accumulator block: IR bit positions
// and the operation encodings produced by the AC command priority encoder.
package mano_pkg;

  localparam int unsigned IR_CLA = 11;
  localparam int unsigned IR_CLE = 10;
  localparam int unsigned IR_CMA = 9;
  localparam int unsigned IR_CME = 8;
  localparam int unsigned IR_CIR = 7;
  localparam int unsigned IR_CIL = 6;
  localparam int unsigned IR_INC = 5;
  localparam int unsigned IR_SPA = 4;
  localparam int unsigned IR_SNA = 3;
  localparam int unsigned IR_SZA = 2;
  localparam int unsigned IR_SZE = 1;
  localparam int unsigned IR_INP = 11;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    CLR = 4'd1,
    AND = 4'd2,
    ADD = 4'd3,
    LDA = 4'd4,
    INP = 4'd5,
    CMA = 4'd6,
    CIR = 4'd7,
    CIL = 4'd8,
    INC = 4'd9
  } ac_op_e;

  // E_ALU: E takes the carry/rotate bit produced by the winning AC operation.
  typedef enum logic [1:0] {
    E_HOLD = 2'd0,
    E_ALU  = 2'd1,
    E_CLR  = 2'd2,
    E_CMP  = 2'd3
  } e_op_e;

endpackage

// File: rtl/mano_ac_decode.sv
// Combinational priority encoder: collapses the decoded command lines into a
// single AC operation and a single E operation (CLA > LD group > INC).
module mano_ac_decode
  import mano_pkg::*;
(
  input  logic        d0_i,
  input  logic        d1_i,
  input  logic        d2_i,
  input  logic        t5_i,
  input  logic        p_i,
  input  logic        r_i,
  input  logic [11:5] b_i,
  output ac_op_e      op_o,
  output e_op_e       e_op_o
);

  ac_op_e op_s;

  // AC operation priority chain
  always_comb begin
    op_s = NOP;
    if (r_i & b_i[IR_CLA]) begin
      op_s = CLR;
    end else if (d1_i & t5_i) begin
      op_s = ADD;
    end else if (d0_i & t5_i) begin
      op_s = AND;
    end else if (d2_i & t5_i) begin
      op_s = LDA;
    end else if (p_i & b_i[IR_INP]) begin
      op_s = INP;
    end else if (r_i & b_i[IR_CMA]) begin
      op_s = CMA;
    end else if (r_i & b_i[IR_CIR]) begin
      op_s = CIR;
    end else if (r_i & b_i[IR_CIL]) begin
      op_s = CIL;
    end else if (r_i & b_i[IR_INC]) begin
      op_s = INC;
    end else begin
      op_s = NOP;
    end
  end

  // E write: only a winning ADD/CIR/CIL overrides CLE, which overrides CME
  always_comb begin
    e_op_o = E_HOLD;
    case (op_s)
      ADD, CIR, CIL: e_op_o = E_ALU;
      default: begin
        if (r_i & b_i[IR_CLE]) begin
          e_op_o = E_CLR;
        end else if (r_i & b_i[IR_CME]) begin
          e_op_o = E_CMP;
        end else begin
          e_op_o = E_HOLD;
        end
      end
    endcase
  end

  assign op_o = op_s;

endmodule

// File: rtl/mano_ac_unit.sv
// Accumulator unit: AC and E registers, AC source ALU, registered operation
// strobes and the combinational skip / FGI-clear outputs.
module mano_ac_unit
  import mano_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int INPR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D0,
  input  logic              D1,
  input  logic              D2,
  input  logic              T5,
  input  logic              P,
  input  logic              R,
  input  logic [11:0]       B,
  input  logic [WIDTH-1:0]  DR,
  input  logic [INPR_W-1:0] INPR,
  output logic [WIDTH-1:0]  AC,
  output logic              E,
  output logic              LdOut,
  output logic              IncOut,
  output logic              ClrOut,
  output logic              fgi_clr,
  output logic              skip
);

  ac_op_e           op_s;
  e_op_e            e_op_s;
  logic [WIDTH:0]   sum_s;
  logic             e_alu_s;
  logic [WIDTH-1:0] ac_d, ac_q;
  logic             e_d, e_q;
  logic             ld_d, ld_q;
  logic             inc_d, inc_q;
  logic             clr_d, clr_q;
  logic             unused_b0_s;

  mano_ac_decode u_decode (
    .d0_i   (D0),
    .d1_i   (D1),
    .d2_i   (D2),
    .t5_i   (T5),
    .p_i    (P),
    .r_i    (R),
    .b_i    (B[11:5]),
    .op_o   (op_s),
    .e_op_o (e_op_s)
  );

  assign sum_s = {1'b0, ac_q} + {1'b0, DR};

  // AC source mux and strobe selection for the winning operation
  always_comb begin
    ac_d    = ac_q;
    e_alu_s = e_q;
    ld_d    = 1'b0;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    case (op_s)
      CLR: begin ac_d = {WIDTH{1'b0}};           clr_d = 1'b1; end
      AND: begin ac_d = ac_q & DR;               ld_d  = 1'b1; end
      ADD: begin
        ac_d    = sum_s[WIDTH-1:0];
        e_alu_s = sum_s[WIDTH];
        ld_d    = 1'b1;
      end
      LDA: begin ac_d = DR;                      ld_d  = 1'b1; end
      INP: begin ac_d[INPR_W-1:0] = INPR;        ld_d  = 1'b1; end
      CMA: begin ac_d = ~ac_q;                   ld_d  = 1'b1; end
      CIR: begin
        ac_d    = {e_q, ac_q[WIDTH-1:1]};
        e_alu_s = ac_q[0];
        ld_d    = 1'b1;
      end
      CIL: begin
        ac_d    = {ac_q[WIDTH-2:0], e_q};
        e_alu_s = ac_q[WIDTH-1];
        ld_d    = 1'b1;
      end
      INC: begin
        ac_d  = ac_q + {{(WIDTH-1){1'b0}}, 1'b1};
        inc_d = 1'b1;
      end
      default: ac_d = ac_q;
    endcase
  end

  // E next-state
  always_comb begin
    e_d = e_q;
    case (e_op_s)
      E_ALU:   e_d = e_alu_s;
      E_CLR:   e_d = 1'b0;
      E_CMP:   e_d = ~e_q;
      default: e_d = e_q;
    endcase
  end

  // State and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q  <= {WIDTH{1'b0}};
      e_q   <= 1'b0;
      ld_q  <= 1'b0;
      inc_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      ac_q  <= ac_d;
      e_q   <= e_d;
      ld_q  <= ld_d;
      inc_q <= inc_d;
      clr_q <= clr_d;
    end
  end

  assign AC     = ac_q;
  assign E      = e_q;
  assign LdOut  = ld_q;
  assign IncOut = inc_q;
  assign ClrOut = clr_q;

  assign fgi_clr = P & B[IR_INP];
  assign skip    = R & ((B[IR_SPA] & ~ac_q[WIDTH-1]) |
                        (B[IR_SNA] &  ac_q[WIDTH-1]) |
                        (B[IR_SZA] & (ac_q == {WIDTH{1'b0}})) |
                        (B[IR_SZE] & ~e_q));

  // B[0] carries no register-reference meaning
  assign unused_b0_s = B[0];

endmodule

// File: tb/tb_mano_ac_unit.sv
// Self-checking bench for mano_ac_unit: directed vector table, reset and
// WIDTH=8 sequences, then random stimulus against a behavioural model.
module tb_mano_ac_unit;

  typedef struct packed {
    logic        d0, d1, d2, t5, p, r;
    logic [11:0] b;
  } ctrl_t;

  typedef struct packed {
    logic [63:0] ac;
    logic        e, ld, inc, clr;
  } mst_t;

  typedef struct {
    ctrl_t       c;
    logic [15:0] dr;
    logic [7:0]  inpr;
    logic [15:0] ac;
    logic        e, ld, inc, clr, skip, fgi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, rst8_n;
  logic D0, D1, D2, T5, P, R;
  logic [11:0] B;
  logic [15:0] DR16, AC16;
  logic [7:0]  INPR16, DR8, INPR8, AC8;
  logic E16, ld16, inc16, clr16, fgi16, skip16;
  logic E8, ld8, inc8, clr8, fgi8, skip8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mano_ac_unit #(.WIDTH(16), .INPR_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .D0(D0), .D1(D1), .D2(D2), .T5(T5), .P(P), .R(R),
    .B(B), .DR(DR16), .INPR(INPR16), .AC(AC16), .E(E16), .LdOut(ld16),
    .IncOut(inc16), .ClrOut(clr16), .fgi_clr(fgi16), .skip(skip16)
  );

  mano_ac_unit #(.WIDTH(8), .INPR_W(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .D0(D0), .D1(D1), .D2(D2), .T5(T5), .P(P), .R(R),
    .B(B), .DR(DR8), .INPR(INPR8), .AC(AC8), .E(E8), .LdOut(ld8),
    .IncOut(inc8), .ClrOut(clr8), .fgi_clr(fgi8), .skip(skip8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input ctrl_t c);
    D0 = c.d0; D1 = c.d1; D2 = c.d2; T5 = c.t5; P = c.p; R = c.r; B = c.b;
  endtask

  function automatic ctrl_t cm(input logic [2:0] d);
    ctrl_t c = '0;
    c.d0 = d[0]; c.d1 = d[1]; c.d2 = d[2]; c.t5 = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t cr(input logic [11:0] b);
    ctrl_t c = '0;
    c.r = 1'b1; c.b = b;
    return c;
  endfunction

  function automatic ctrl_t cp(input logic [11:0] b);
    ctrl_t c = '0;
    c.p = 1'b1; c.b = b;
    return c;
  endfunction

  function automatic ctrl_t cmr(input logic [2:0] d, input logic [11:0] b);
    ctrl_t c = cm(d);
    c.r = 1'b1; c.b = b;
    return c;
  endfunction

  function automatic vec_t mk(input ctrl_t c, input logic [15:0] dr, input logic [7:0] inpr,
                              input logic [15:0] ac, input logic e, input logic ld,
                              input logic inc, input logic clr, input logic skp, input logic fgi);
    vec_t v;
    v.c = c; v.dr = dr; v.inpr = inpr; v.ac = ac; v.e = e;
    v.ld = ld; v.inc = inc; v.clr = clr; v.skip = skp; v.fgi = fgi;
    return v;
  endfunction

  // Reference model: one clock of the accumulator, straight from the command rules.
  function automatic mst_t mnext(input mst_t s, input ctrl_t c, input int w, input int iw,
                                 input logic [63:0] dr, input logic [63:0] inpr);
    mst_t n;
    logic [63:0] mask, imask;
    logic [64:0] sum;
    bit cla, add, andc, lda, inp, cma, cir, cil, inc, cle, cme, e_set;
    mask  = (64'd1 << w) - 64'd1;
    imask = (64'd1 << iw) - 64'd1;
    cla  = c.r & c.b[11]; cle = c.r & c.b[10]; cma = c.r & c.b[9];
    cme  = c.r & c.b[8];  cir = c.r & c.b[7];  cil = c.r & c.b[6];
    inc  = c.r & c.b[5];  inp = c.p & c.b[11];
    add  = c.d1 & c.t5;   andc = c.d0 & c.t5;  lda = c.d2 & c.t5;
    n = s; n.ld = 1'b0; n.inc = 1'b0; n.clr = 1'b0; e_set = 1'b0;
    if (cla) begin
      n.ac = 64'd0; n.clr = 1'b1;
    end else if (add) begin
      sum = {1'b0, s.ac} + {1'b0, dr};
      n.ac = sum[63:0] & mask; n.e = sum[w]; e_set = 1'b1; n.ld = 1'b1;
    end else if (andc) begin
      n.ac = s.ac & dr; n.ld = 1'b1;
    end else if (lda) begin
      n.ac = dr & mask; n.ld = 1'b1;
    end else if (inp) begin
      n.ac = (s.ac & ~imask) | (inpr & imask); n.ld = 1'b1;
    end else if (cma) begin
      n.ac = ~s.ac & mask; n.ld = 1'b1;
    end else if (cir) begin
      n.ac = (s.ac >> 1) | (64'(s.e) << (w - 1)); n.e = s.ac[0]; e_set = 1'b1; n.ld = 1'b1;
    end else if (cil) begin
      n.ac = ((s.ac << 1) | 64'(s.e)) & mask; n.e = s.ac[w-1]; e_set = 1'b1; n.ld = 1'b1;
    end else if (inc) begin
      n.ac = (s.ac + 64'd1) & mask; n.inc = 1'b1;
    end
    if (!e_set) begin
      if (cle)      n.e = 1'b0;
      else if (cme) n.e = ~s.e;
    end
    return n;
  endfunction

  function automatic logic mskip(input mst_t s, input ctrl_t c, input int w);
    logic msb;
    msb = s.ac[w-1];
    return c.r & ((c.b[4] & ~msb) | (c.b[3] & msb) | (c.b[2] & (s.ac == 64'd0)) | (c.b[1] & ~s.e));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[$];
    ctrl_t c0 = '0;
    ctrl_t c;
    mst_t  m16, m8;

    rst_n = 1'b0; rst8_n = 1'b0;
    set_ctrl(c0);
    DR16 = 16'h0; INPR16 = 8'h0; DR8 = 8'h0; INPR8 = 8'h0;

    //     ctrl                    dr       inpr   ac       e     ld    inc   clr   skip  fgi
    tbl.push_back(mk(cm(3'b100),         16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cm(3'b010),         16'h0001, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(c0,                 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cm(3'b100),         16'h8001, 8'h00, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h080),        16'h0000, 8'h00, 16'hC000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h040),        16'h0000, 8'h00, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cm(3'b100),         16'hFFFF, 8'h00, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h020),        16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h004),        16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(cm(3'b100),         16'hAB00, 8'h00, 16'hAB00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cp(12'h800),        16'h0000, 8'h5C, 16'hAB5C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(cr(12'h820),        16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h400),        16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h100),        16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h002),        16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h500),        16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h002),        16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(cr(12'h200),        16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cr(12'h008),        16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(cr(12'h010),        16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cmr(3'b010, 12'h080), 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cm(3'b100),         16'hFFFF, 8'h00, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cmr(3'b010, 12'h400), 16'h0002, 8'h00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cm(3'b101),         16'h0F0F, 8'h00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(cmr(3'b100, 12'h020), 16'h1234, 8'h00, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    chk("reset ac", {48'd0, AC16}, 64'd0);
    chk("reset e", {63'd0, E16}, 64'd0);
    chk("reset strobes", {61'd0, ld16, inc16, clr16}, 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_ctrl(tbl[i].c);
      DR16 = tbl[i].dr; INPR16 = tbl[i].inpr;
      #1;
      chk($sformatf("row%0d skip", i), {63'd0, skip16}, {63'd0, tbl[i].skip});
      chk($sformatf("row%0d fgi_clr", i), {63'd0, fgi16}, {63'd0, tbl[i].fgi});
      @(posedge clk); #1;
      chk($sformatf("row%0d ac", i), {48'd0, AC16}, {48'd0, tbl[i].ac});
      chk($sformatf("row%0d e", i), {63'd0, E16}, {63'd0, tbl[i].e});
      chk($sformatf("row%0d strobes", i), {61'd0, ld16, inc16, clr16},
          {61'd0, tbl[i].ld, tbl[i].inc, tbl[i].clr});
      @(negedge clk);
    end

    // Asynchronous reset in mid-cycle with AC=0x1234, E=1 and an LDA pending
    set_ctrl(cm(3'b100)); DR16 = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ac", {48'd0, AC16}, 64'd0);
    chk("async rst e", {63'd0, E16}, 64'd0);
    chk("async rst strobes", {61'd0, ld16, inc16, clr16}, 64'd0);
    @(posedge clk); #1;
    chk("rst held ac", {48'd0, AC16}, 64'd0);
    @(negedge clk);
    set_ctrl(c0); rst_n = 1'b1;

    // WIDTH=8: 0x7F + 0x01 -> 0x80, then sign/positive skips
    rst8_n = 1'b1;
    set_ctrl(cm(3'b100)); DR8 = 8'h7F;
    @(posedge clk); #1;
    chk("w8 lda ac", {56'd0, AC8}, 64'h7F);
    @(negedge clk);
    set_ctrl(cm(3'b010)); DR8 = 8'h01;
    @(posedge clk); #1;
    chk("w8 add ac", {56'd0, AC8}, 64'h80);
    chk("w8 add e", {63'd0, E8}, 64'd0);
    chk("w8 add ld", {63'd0, ld8}, 64'd1);
    @(negedge clk);
    set_ctrl(cr(12'h008)); #1;
    chk("w8 sna skip", {63'd0, skip8}, 64'd1);
    set_ctrl(cr(12'h010)); #1;
    chk("w8 spa skip", {63'd0, skip8}, 64'd0);
    @(negedge clk);

    // Random phase on both widths against the model
    set_ctrl(c0); rst_n = 1'b0; rst8_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;
    m16 = '0; m8 = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2; rst_n = 1'b0; rst8_n = 1'b0;
        #1;
        chk("rand rst ac16", {48'd0, AC16}, 64'd0);
        chk("rand rst ac8", {56'd0, AC8}, 64'd0);
        m16 = '0; m8 = '0;
        @(negedge clk);
        rst_n = 1'b1; rst8_n = 1'b1;
      end
      {c.d0, c.d1, c.d2, c.t5, c.p, c.r} = 6'($urandom);
      c.b = 12'($urandom & $urandom);
      set_ctrl(c);
      DR16 = 16'($urandom); INPR16 = 8'($urandom);
      DR8 = 8'($urandom); INPR8 = 8'($urandom);
      #1;
      chk("rand skip16", {63'd0, skip16}, {63'd0, mskip(m16, c, 16)});
      chk("rand skip8", {63'd0, skip8}, {63'd0, mskip(m8, c, 8)});
      chk("rand fgi16", {63'd0, fgi16}, {63'd0, c.p & c.b[11]});
      chk("rand fgi8", {63'd0, fgi8}, {63'd0, c.p & c.b[11]});
      m16 = mnext(m16, c, 16, 8, {48'd0, DR16}, {56'd0, INPR16});
      m8  = mnext(m8, c, 8, 8, {56'd0, DR8}, {56'd0, INPR8});
      @(posedge clk); #1;
      chk($sformatf("rand%0d ac16", i), {48'd0, AC16}, m16.ac);
      chk($sformatf("rand%0d e16", i), {63'd0, E16}, {63'd0, m16.e});
      chk($sformatf("rand%0d strobes16", i), {61'd0, ld16, inc16, clr16},
          {61'd0, m16.ld, m16.inc, m16.clr});
      chk($sformatf("rand%0d ac8", i), {56'd0, AC8}, m8.ac);
      chk($sformatf("rand%0d e8", i), {63'd0, E8}, {63'd0, m8.e});
      chk($sformatf("rand%0d strobes8", i), {61'd0, ld8, inc8, clr8},
          {61'd0, m8.ld, m8.inc, m8.clr});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
